// File: rtl/bbv3_pkg.sv
// Shared types and default timing for the BusBlasterV3 JTAG reset sequencer.
// The state enum, the counter width and the default cycle counts live here.
package bbv3_pkg;

   localparam int CNT_W = 16;

   localparam logic [CNT_W-1:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
   localparam logic [CNT_W-1:0] DEF_PULSE_CYCLES    = 16'd10000;
   localparam logic [CNT_W-1:0] DEF_SETTLE_CYCLES   = 16'd20000;
   localparam bit               DEF_TRST_WITH_SRST  = 1'b1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      HOLD    = 2'd2,
      RELEASE = 2'd3
   } seq_state_e;

   // States in which the sequencer itself pulls nSRST low.
   function automatic logic drives_low(input seq_state_e state);
      return (state == ASSERT) || (state == HOLD);
   endfunction

endpackage

// File: rtl/bbv3_reset_sequencer_if.sv
// Host/target signal bundle of the reset sequencer: request inputs, nSRST
// sense, pin controls and status readback.
interface bbv3_reset_sequencer_if;

   logic host_srst_req;
   logic host_trst_req;
   logic srst_sense;
   logic nsrst_oe;
   logic ntrst;
   logic srst_busy;
   logic settle_timeout;
   logic ext_reset_seen;

   modport master (
      output host_srst_req,
      output host_trst_req,
      output srst_sense,
      input  nsrst_oe,
      input  ntrst,
      input  srst_busy,
      input  settle_timeout,
      input  ext_reset_seen
   );

   modport slave (
      input  host_srst_req,
      input  host_trst_req,
      input  srst_sense,
      output nsrst_oe,
      output ntrst,
      output srst_busy,
      output settle_timeout,
      output ext_reset_seen
   );

endinterface

// File: rtl/bbv3_debounce.sv
// BUTTON front end: 2-flop synchroniser, saturating debounce counter and a
// registered one-cycle press pulse on the debounced high-to-low transition.
module bbv3_debounce #(
   parameter int               CNT_W           = bbv3_pkg::CNT_W,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = bbv3_pkg::DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic button_n,
   output logic press_event
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LIMIT    = DEBOUNCE_CYCLES - CNT_ONE;

   logic             btn_meta_r;
   logic             btn_sync_r;
   logic             btn_state_r;
   logic             press_r;
   logic [CNT_W-1:0] cnt_r;
   logic             mismatch_s;
   logic             flip_s;

   // Flip when this sample completes the required run of mismatches.
   always_comb begin
      mismatch_s = btn_sync_r ^ btn_state_r;
      flip_s     = mismatch_s && (cnt_r >= LIMIT);
   end

   // Synchroniser, mismatch run counter, debounced level and press pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_meta_r  <= 1'b1;
         btn_sync_r  <= 1'b1;
         btn_state_r <= 1'b1;
         press_r     <= 1'b0;
         cnt_r       <= CNT_ZERO;
      end else begin
         btn_meta_r <= button_n;
         btn_sync_r <= btn_meta_r;
         press_r    <= flip_s & btn_state_r;
         if (!mismatch_s) begin
            cnt_r <= CNT_ZERO;
         end else if (flip_s) begin
            btn_state_r <= btn_sync_r;
            cnt_r       <= CNT_ZERO;
         end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign press_event = press_r;

endmodule

// File: rtl/bbv3_reset_sequencer.sv
// JTAG nSRST/nTRST reset sequencer: arbitrates host and button requests into
// one timed nSRST pulse, waits for release, and flags target-driven resets.
module bbv3_reset_sequencer #(
   parameter int               CNT_W           = bbv3_pkg::CNT_W,
   parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = bbv3_pkg::DEF_DEBOUNCE_CYCLES,
   parameter logic [CNT_W-1:0] PULSE_CYCLES    = bbv3_pkg::DEF_PULSE_CYCLES,
   parameter logic [CNT_W-1:0] SETTLE_CYCLES   = bbv3_pkg::DEF_SETTLE_CYCLES,
   parameter bit               TRST_WITH_SRST  = bbv3_pkg::DEF_TRST_WITH_SRST
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    button_n,
   output logic                    led,
   bbv3_reset_sequencer_if.slave   bus
);

   import bbv3_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PULSE_LAST  = PULSE_CYCLES - CNT_ONE;
   localparam logic [CNT_W-1:0] SETTLE_LAST = SETTLE_CYCLES - CNT_ONE;

   logic             host_srst_meta_r, host_srst_sync_r;
   logic             host_trst_meta_r, host_trst_sync_r;
   logic             sense_meta_r, sense_sync_r;
   logic             press_s;
   logic             req_s;

   seq_state_e       state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic             timeout_hit_s;

   logic             nsrst_oe_r, ntrst_r, led_r, busy_r, settle_timeout_r, ext_reset_seen_r;
   logic             nsrst_oe_nxt_s, ntrst_nxt_s, led_nxt_s, busy_nxt_s;
   logic             settle_timeout_nxt_s, ext_reset_seen_nxt_s;
   logic             drive_s;

   bbv3_debounce #(
      .CNT_W           (CNT_W),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .button_n    (button_n),
      .press_event (press_s)
   );

   // Two-flop synchronisers; sense idles high so reset does not look like a target reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         host_srst_meta_r <= 1'b0;
         host_srst_sync_r <= 1'b0;
         host_trst_meta_r <= 1'b0;
         host_trst_sync_r <= 1'b0;
         sense_meta_r     <= 1'b1;
         sense_sync_r     <= 1'b1;
      end else begin
         host_srst_meta_r <= bus.host_srst_req;
         host_srst_sync_r <= host_srst_meta_r;
         host_trst_meta_r <= bus.host_trst_req;
         host_trst_sync_r <= host_trst_meta_r;
         sense_meta_r     <= bus.srst_sense;
         sense_sync_r     <= sense_meta_r;
      end
   end

   assign req_s = host_srst_sync_r | press_s;

   // Next-state and shared down-counter; presses outside IDLE are simply ignored.
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      timeout_hit_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (req_s) begin
               state_nxt_s = ASSERT;
               cnt_nxt_s   = PULSE_LAST;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ASSERT: begin
            if (cnt_r != CNT_ZERO) begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end else if (host_srst_sync_r) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = RELEASE;
               cnt_nxt_s   = SETTLE_LAST;
            end
         end
         HOLD: begin
            if (host_srst_sync_r) begin
               state_nxt_s = HOLD;
            end else begin
               state_nxt_s = RELEASE;
               cnt_nxt_s   = SETTLE_LAST;
            end
         end
         RELEASE: begin
            if (sense_sync_r) begin
               state_nxt_s = IDLE;
            end else if (cnt_r == CNT_ZERO) begin
               state_nxt_s   = IDLE;
               timeout_hit_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Output values derived from the upcoming state so they land with the transition.
   always_comb begin
      drive_s        = drives_low(state_nxt_s);
      nsrst_oe_nxt_s = drive_s;
      busy_nxt_s     = (state_nxt_s != IDLE);
      ntrst_nxt_s    = ~(host_trst_sync_r | (TRST_WITH_SRST & drive_s));
      if ((state_r == IDLE) && req_s) begin
         settle_timeout_nxt_s = 1'b0;
         ext_reset_seen_nxt_s = 1'b0;
      end else begin
         settle_timeout_nxt_s = settle_timeout_r | timeout_hit_s;
         ext_reset_seen_nxt_s = ext_reset_seen_r | ((state_r == IDLE) & ~sense_sync_r);
      end
      led_nxt_s = busy_nxt_s | ~ntrst_nxt_s | ext_reset_seen_nxt_s;
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= IDLE;
         cnt_r            <= CNT_ZERO;
         nsrst_oe_r       <= 1'b0;
         ntrst_r          <= 1'b1;
         led_r            <= 1'b0;
         busy_r           <= 1'b0;
         settle_timeout_r <= 1'b0;
         ext_reset_seen_r <= 1'b0;
      end else begin
         state_r          <= state_nxt_s;
         cnt_r            <= cnt_nxt_s;
         nsrst_oe_r       <= nsrst_oe_nxt_s;
         ntrst_r          <= ntrst_nxt_s;
         led_r            <= led_nxt_s;
         busy_r           <= busy_nxt_s;
         settle_timeout_r <= settle_timeout_nxt_s;
         ext_reset_seen_r <= ext_reset_seen_nxt_s;
      end
   end

   assign bus.nsrst_oe       = nsrst_oe_r;
   assign bus.ntrst          = ntrst_r;
   assign bus.srst_busy      = busy_r;
   assign bus.settle_timeout = settle_timeout_r;
   assign bus.ext_reset_seen = ext_reset_seen_r;
   assign led                = led_r;

endmodule

// File: tb/tb_bbv3_reset_sequencer.sv
// Bench for bbv3_reset_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a behavioural reference model.
module tb_bbv3_reset_sequencer;

   localparam int DEB    = 4;
   localparam int PULSE  = 8;
   localparam int SETTLE = 6;

   logic clk = 1'b0;
   logic rst;
   logic button_n;
   logic led;

   bbv3_reset_sequencer_if bus ();

   bbv3_reset_sequencer #(
      .CNT_W           (16),
      .DEBOUNCE_CYCLES (16'd4),
      .PULSE_CYCLES    (16'd8),
      .SETTLE_CYCLES   (16'd6),
      .TRST_WITH_SRST  (1'b1)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .button_n (button_n),
      .led      (led),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // stimulus knobs
   bit host_req, trst_req, btn, target_low;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // observations of the DUT nSRST pin over a scenario
   int obs_oe_cycles, obs_rises, obs_first_rise, obs_fall, obs_ntrst_low;
   bit prev_oe = 1'b0;

   // reference model
   bit    hs_pipe[2], ht_pipe[2], bt_pipe[2], sn_pipe[2];
   bit    m_btn_level, m_press, m_timeout, m_ext;
   int    m_btn_run, m_left;
   string m_phase = "IDLE";
   bit    e_oe = 1'b0, e_ntrst = 1'b1, e_led = 1'b0, e_busy = 1'b0;
   bit    sense_in;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic clear_obs();
      obs_oe_cycles  = 0;
      obs_rises      = 0;
      obs_first_rise = -1;
      obs_fall       = -1;
      obs_ntrst_low  = 0;
   endtask

   // One clock edge of the specified behaviour, using the inputs held before the edge.
   task automatic model_step();
      bit hs, ht, bs, sn, press, req;
      if (rst) begin
         hs_pipe = '{1'b0, 1'b0};
         ht_pipe = '{1'b0, 1'b0};
         bt_pipe = '{1'b1, 1'b1};
         sn_pipe = '{1'b1, 1'b1};
         m_btn_level = 1'b1;
         m_btn_run   = 0;
         m_press     = 1'b0;
         m_phase     = "IDLE";
         m_left      = 0;
         m_timeout   = 1'b0;
         m_ext       = 1'b0;
         ht          = 1'b0;
      end else begin
         // values that have made it through the two synchroniser stages
         hs = hs_pipe[1]; ht = ht_pipe[1]; bs = bt_pipe[1]; sn = sn_pipe[1];
         press = m_press;
         hs_pipe[1] = hs_pipe[0]; hs_pipe[0] = host_req;
         ht_pipe[1] = ht_pipe[0]; ht_pipe[0] = trst_req;
         bt_pipe[1] = bt_pipe[0]; bt_pipe[0] = btn;
         sn_pipe[1] = sn_pipe[0]; sn_pipe[0] = sense_in;

         m_press = 1'b0;
         if (bs == m_btn_level) begin
            m_btn_run = 0;
         end else begin
            m_btn_run++;
            if (m_btn_run == DEB) begin
               m_btn_level = bs;
               m_btn_run   = 0;
               m_press     = (bs == 1'b0);
            end
         end

         req = hs || press;
         if (m_phase == "IDLE") begin
            if (req) begin
               m_timeout = 1'b0;
               m_ext     = 1'b0;
               m_phase   = "ASSERT";
               m_left    = PULSE;
            end else if (!sn) begin
               m_ext = 1'b1;
            end
         end else if (m_phase == "ASSERT") begin
            m_left--;
            if (m_left == 0) begin
               if (hs) m_phase = "HOLD";
               else begin m_phase = "RELEASE"; m_left = SETTLE; end
            end
         end else if (m_phase == "HOLD") begin
            if (!hs) begin m_phase = "RELEASE"; m_left = SETTLE; end
         end else begin
            if (sn) m_phase = "IDLE";
            else begin
               m_left--;
               if (m_left == 0) begin m_timeout = 1'b1; m_phase = "IDLE"; end
            end
         end
      end
      e_oe    = (m_phase == "ASSERT") || (m_phase == "HOLD");
      e_busy  = (m_phase != "IDLE");
      e_ntrst = rst ? 1'b1 : !(ht || e_oe);
      e_led   = e_busy || !e_ntrst || m_ext;
   endtask

   // Apply inputs, clock once, advance the model and compare every output.
   task automatic tick();
      sense_in               = !(e_oe || target_low);
      bus.host_srst_req      = host_req;
      bus.host_trst_req      = trst_req;
      bus.srst_sense         = sense_in;
      button_n               = btn;
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      check_val("nsrst_oe", bus.nsrst_oe, e_oe);
      check_val("ntrst", bus.ntrst, e_ntrst);
      check_val("led", led, e_led);
      check_val("srst_busy", bus.srst_busy, e_busy);
      check_val("settle_timeout", bus.settle_timeout, m_timeout);
      check_val("ext_reset_seen", bus.ext_reset_seen, m_ext);
      if (bus.nsrst_oe === 1'b1) begin
         obs_oe_cycles++;
         if (!prev_oe) begin
            obs_rises++;
            if (obs_first_rise < 0) obs_first_rise = cyc;
         end
      end else if (prev_oe) begin
         obs_fall = cyc;
      end
      if (bus.ntrst === 1'b0) obs_ntrst_low++;
      prev_oe = (bus.nsrst_oe === 1'b1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int t0, tf;
      rst = 1'b1; host_req = 1'b0; trst_req = 1'b0; btn = 1'b1; target_low = 1'b0;
      clear_obs();
      run(3);
      check_val("reset_oe", bus.nsrst_oe, 0);
      check_val("reset_ntrst", bus.ntrst, 1);
      check_val("reset_led", led, 0);
      check_val("reset_busy", bus.srst_busy, 0);
      rst = 1'b0;
      run(5);

      // host pulse
      clear_obs(); t0 = cyc;
      host_req = 1'b1; run(2); host_req = 1'b0; run(20);
      check_val("pulse_start", obs_first_rise, t0 + 3);
      check_val("pulse_len", obs_oe_cycles, PULSE);
      check_val("pulse_trst_len", obs_ntrst_low, PULSE);
      check_val("pulse_busy_end", bus.srst_busy, 0);

      // host hold
      clear_obs(); t0 = cyc;
      host_req = 1'b1; run(30); host_req = 1'b0; tf = cyc; run(20);
      check_val("hold_start", obs_first_rise, t0 + 3);
      check_val("hold_release", obs_fall, tf + 3);
      check_val("hold_len", obs_oe_cycles, 30);

      // button bounce on press and on release
      clear_obs();
      for (int i = 0; i < 10; i++) begin btn = ((i / 2) % 2 == 0); run(1); end
      btn = 1'b0; t0 = cyc; run(30);
      for (int i = 0; i < 10; i++) begin btn = ((i / 2) % 2 == 0); run(1); end
      btn = 1'b1; run(20);
      check_val("button_seq_count", obs_rises, 1);
      check_val("button_start", obs_first_rise, t0 + 7);
      check_val("button_len", obs_oe_cycles, PULSE);

      // settle timeout
      clear_obs(); target_low = 1'b1; t0 = cyc;
      host_req = 1'b1; run(2); host_req = 1'b0; run(13);
      target_low = 1'b0; run(1);
      check_val("timeout_early", bus.settle_timeout, 0);
      run(1);
      check_val("timeout_set", bus.settle_timeout, 1);
      check_val("timeout_ext", bus.ext_reset_seen, 0);
      check_val("timeout_busy", bus.srst_busy, 0);
      run(5);
      check_val("timeout_sticky", bus.settle_timeout, 1);
      check_val("timeout_ext_idle", bus.ext_reset_seen, 0);
      host_req = 1'b1; run(2); host_req = 1'b0; run(1);
      check_val("timeout_cleared", bus.settle_timeout, 0);
      run(20);

      // external target reset
      clear_obs();
      target_low = 1'b1; run(3); target_low = 1'b0; run(5);
      check_val("ext_seen", bus.ext_reset_seen, 1);
      check_val("ext_led", led, 1);
      check_val("ext_no_drive", obs_oe_cycles, 0);

      // reset in ASSERT cycle 4, then simultaneous host and button
      host_req = 1'b1; run(2); host_req = 1'b0; run(4);
      check_val("midrst_asserting", bus.nsrst_oe, 1);
      rst = 1'b1; run(1); rst = 1'b0;
      check_val("midrst_oe", bus.nsrst_oe, 0);
      check_val("midrst_ntrst", bus.ntrst, 1);
      check_val("midrst_busy", bus.srst_busy, 0);
      clear_obs();
      host_req = 1'b1; btn = 1'b0; run(2); host_req = 1'b0; run(30);
      btn = 1'b1; run(15);
      check_val("dual_seq_count", obs_rises, 1);
      check_val("dual_len", obs_oe_cycles, PULSE);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 19) == 0) host_req = ~host_req;
         if ($urandom_range(0, 39) == 0) trst_req = ~trst_req;
         if ($urandom_range(0, 14) == 0) btn = ~btn;
         if ($urandom_range(0, 59) == 0) target_low = ~target_low;
         rst = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; host_req = 1'b0; trst_req = 1'b0; btn = 1'b1; target_low = 1'b0;
      run(40);
      check_val("final_busy", bus.srst_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
